// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with not-taken prediction, redirect flush and halt
module pc_sequencer #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_PC     = '0,
    parameter int               FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc,
    output logic             fetch_en,
    output logic             flush,
    output logic             halted,
    output logic [15:0]      taken_count
);

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    localparam logic [3:0] OP_HALT    = 4'b1111;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t           state;
    logic [2:0]       flush_cnt;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] id_fallthrough;
    logic             is_branch;
    logic             redirect;

    assign pc_seq         = pc + WIDTH'(2);
    assign id_fallthrough = id_pc + WIDTH'(2);
    assign is_branch      = (id_opcode == 4'b0100) || (id_opcode == 4'b0101) ||
                            (id_opcode == 4'b0110);
    // A taken branch whose target equals the fall-through address needs no redirect.
    assign redirect       = id_valid && is_branch && (branch_target != id_fallthrough);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fetch_en    <= 1'b0;
            flush       <= 1'b0;
            halted      <= 1'b0;
            taken_count <= '0;
            flush_cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    // fetch_en is low in RUN only on the first edge out of reset.
                    if (!fetch_en) begin
                        fetch_en <= 1'b1;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (id_valid && id_opcode == OP_HALT) begin
                        state    <= HALT;
                        fetch_en <= 1'b0;
                        halted   <= 1'b1;
                    end else if (redirect) begin
                        pc        <= branch_target;
                        flush     <= 1'b1;
                        flush_cnt <= FLUSH_LOAD;
                        state     <= FLUSH;
                        if (taken_count != 16'hFFFF) begin
                            taken_count <= taken_count + 16'd1;
                        end
                    end else begin
                        pc <= pc_seq;
                    end
                end
                FLUSH: begin
                    pc <= pc_seq;
                    if (flush_cnt == 3'd0) begin
                        flush <= 1'b0;
                        state <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                HALT: begin
                    pc <= pc;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - bench for pc_sequencer with FLUSH_CYCLES=1 and FLUSH_CYCLES=3 instances
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  id_opcode = 4'h0;
    logic [15:0] id_pc = 16'h0;
    logic [15:0] branch_target = 16'h0;

    logic [15:0] pc_o [2];
    logic        fe_o [2];
    logic        fl_o [2];
    logic        h_o  [2];
    logic [15:0] tc_o [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(16), .RESET_PC(16'h0010), .FLUSH_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_pc(id_pc), .branch_target(branch_target), .pc(pc_o[0]), .fetch_en(fe_o[0]),
        .flush(fl_o[0]), .halted(h_o[0]), .taken_count(tc_o[0])
    );

    pc_sequencer #(.WIDTH(16), .RESET_PC(16'h0010), .FLUSH_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .stall(stall), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_pc(id_pc), .branch_target(branch_target), .pc(pc_o[1]), .fetch_en(fe_o[1]),
        .flush(fl_o[1]), .halted(h_o[1]), .taken_count(tc_o[1])
    );

    // Reference model: bubbles remaining after a redirect, plus halted/started flags.
    int          fc [2] = '{1, 3};
    logic [15:0] m_pc [2];
    logic        m_fe [2];
    logic        m_fl [2];
    logic        m_h  [2];
    logic [15:0] m_tc [2];
    int          m_left [2];
    logic        m_live [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 16'h0010; m_fe[k] = 1'b0; m_fl[k] = 1'b0; m_h[k] = 1'b0;
            m_tc[k] = 16'h0; m_left[k] = 0; m_live[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [15:0] fall;
        fall = id_pc + 16'd2;
        for (int k = 0; k < 2; k++) begin
            if (!m_live[k]) begin
                m_live[k] = 1'b1;
                m_fe[k] = 1'b1;
            end else if (m_h[k]) begin
                m_h[k] = 1'b1;
            end else if (m_left[k] > 0) begin
                m_pc[k] = m_pc[k] + 16'd2;
                m_left[k] = m_left[k] - 1;
                m_fl[k] = (m_left[k] > 0);
            end else if (stall) begin
                m_pc[k] = m_pc[k];
            end else if (id_valid && id_opcode == 4'hF) begin
                m_h[k] = 1'b1;
                m_fe[k] = 1'b0;
            end else if (id_valid && id_opcode >= 4'h4 && id_opcode <= 4'h6 && branch_target != fall) begin
                m_pc[k] = branch_target;
                m_fl[k] = 1'b1;
                m_left[k] = fc[k];
                if (m_tc[k] != 16'hFFFF) m_tc[k] = m_tc[k] + 16'd1;
            end else begin
                m_pc[k] = m_pc[k] + 16'd2;
            end
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            chk16($sformatf("model u%0d pc", k), pc_o[k], m_pc[k]);
            chk1($sformatf("model u%0d fetch_en", k), fe_o[k], m_fe[k]);
            chk1($sformatf("model u%0d flush", k), fl_o[k], m_fl[k]);
            chk1($sformatf("model u%0d halted", k), h_o[k], m_h[k]);
            chk16($sformatf("model u%0d taken_count", k), tc_o[k], m_tc[k]);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [3:0] op,
                         input logic [15:0] ip, input logic [15:0] tg);
        stall = s; id_valid = v; id_opcode = op; id_pc = ip; branch_target = tg;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
        model_reset();
        #1;
        check_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        s, v;
        logic [3:0]  op;
        logic [15:0] ip, tg, e_pc;
        logic        e_fl, e_fe, e_h;
        logic [15:0] e_tc;
    } vec_t;

    vec_t tbl [18];
    int   n_vec = 0;

    task automatic vec(input logic s, input logic v, input logic [3:0] op, input logic [15:0] ip,
                       input logic [15:0] tg, input logic [15:0] epc, input logic efl,
                       input logic efe, input logic eh, input logic [15:0] etc);
        tbl[n_vec] = '{s, v, op, ip, tg, epc, efl, efe, eh, etc};
        n_vec++;
    endtask

    initial begin
        int nfl;
        model_reset();

        // Expected outputs of the FLUSH_CYCLES=1 instance after each edge.
        vec(1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0010, 1'b0, 1'b1, 1'b0, 16'd0);
        vec(1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0012, 1'b0, 1'b1, 1'b0, 16'd0);
        vec(1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0014, 1'b0, 1'b1, 1'b0, 16'd0);
        vec(1'b0, 1'b1, 4'h4, 16'h0020, 16'h0040, 16'h0040, 1'b1, 1'b1, 1'b0, 16'd1);
        vec(1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0042, 1'b0, 1'b1, 1'b0, 16'd1);
        vec(1'b0, 1'b1, 4'h5, 16'h0020, 16'h0022, 16'h0044, 1'b0, 1'b1, 1'b0, 16'd1);
        vec(1'b1, 1'b1, 4'h6, 16'h0040, 16'h0080, 16'h0044, 1'b0, 1'b1, 1'b0, 16'd1);
        vec(1'b1, 1'b1, 4'h6, 16'h0040, 16'h0080, 16'h0044, 1'b0, 1'b1, 1'b0, 16'd1);
        vec(1'b1, 1'b1, 4'h6, 16'h0040, 16'h0080, 16'h0044, 1'b0, 1'b1, 1'b0, 16'd1);
        vec(1'b0, 1'b1, 4'h6, 16'h0040, 16'h0080, 16'h0080, 1'b1, 1'b1, 1'b0, 16'd2);
        vec(1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0082, 1'b0, 1'b1, 1'b0, 16'd2);
        vec(1'b0, 1'b0, 4'h4, 16'h0000, 16'h0100, 16'h0084, 1'b0, 1'b1, 1'b0, 16'd2);
        vec(1'b0, 1'b1, 4'h3, 16'h0000, 16'h0200, 16'h0086, 1'b0, 1'b1, 1'b0, 16'd2);
        vec(1'b0, 1'b1, 4'h4, 16'h0086, 16'h002E, 16'h002E, 1'b1, 1'b1, 1'b0, 16'd3);
        vec(1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0030, 1'b0, 1'b1, 1'b0, 16'd3);
        vec(1'b0, 1'b1, 4'hF, 16'h0030, 16'h0000, 16'h0030, 1'b0, 1'b0, 1'b1, 16'd3);
        vec(1'b0, 1'b1, 4'h4, 16'h0000, 16'h0900, 16'h0030, 1'b0, 1'b0, 1'b1, 16'd3);
        vec(1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0030, 1'b0, 1'b0, 1'b1, 16'd3);

        do_reset();
        for (int i = 0; i < n_vec; i++) begin
            drive(tbl[i].s, tbl[i].v, tbl[i].op, tbl[i].ip, tbl[i].tg);
            step();
            chk16($sformatf("vec%0d pc", i), pc_o[0], tbl[i].e_pc);
            chk1($sformatf("vec%0d flush", i), fl_o[0], tbl[i].e_fl);
            chk1($sformatf("vec%0d fetch_en", i), fe_o[0], tbl[i].e_fe);
            chk1($sformatf("vec%0d halted", i), h_o[0], tbl[i].e_h);
            chk16($sformatf("vec%0d taken_count", i), tc_o[0], tbl[i].e_tc);
        end

        // Wrap through 16'hFFFE and a second redirect inside the 3-cycle flush window.
        do_reset();
        step();
        nfl = 0;
        drive(1'b0, 1'b1, 4'h4, 16'h0010, 16'hFFFC);
        step(); nfl += int'(fl_o[1]);
        drive(1'b0, 1'b1, 4'h5, 16'h0000, 16'h0500);
        step(); nfl += int'(fl_o[1]);
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        step(); nfl += int'(fl_o[1]);
        chk16("wrap u1 pc", pc_o[0], 16'h0000);
        chk16("wrap u3 pc", pc_o[1], 16'h0000);
        step(); nfl += int'(fl_o[1]);
        step(); nfl += int'(fl_o[1]);
        chk16("flush3 high cycles", 16'(nfl), 16'd3);
        chk16("flush3 taken_count", tc_o[1], 16'd1);
        chk16("flush3 pc", pc_o[1], 16'h0004);

        // Reset asserted in the second flush cycle of the 3-cycle instance.
        do_reset();
        step();
        drive(1'b0, 1'b1, 4'h6, 16'h0100, 16'h0400);
        step();
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        step();
        chk1("midflush flush before rst", fl_o[1], 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        chk16("midflush rst pc", pc_o[1], 16'h0010);
        chk1("midflush rst flush", fl_o[1], 1'b0);
        chk16("midflush rst taken_count", tc_o[1], 16'd0);
        chk1("midflush rst fetch_en", fe_o[1], 1'b0);
        check_model();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                logic [3:0]  op;
                logic [15:0] ip;
                logic [15:0] tg;
                if ($urandom_range(0, 1) == 0) op = 4'(4 + $urandom_range(0, 2));
                else if ($urandom_range(0, 63) == 0) op = 4'hF;
                else op = 4'($urandom_range(0, 14));
                ip = 16'($urandom);
                if ($urandom_range(0, 7) == 0) ip = 16'hFFFE;
                tg = ($urandom_range(0, 2) == 0) ? ip + 16'd2 : 16'($urandom);
                drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), op, ip, tg);
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 16-bit core. It owns the fetch PC and advances it by 2 each cycle, predicting every branch as not taken. It holds the PC on hazard stalls and redirects the PC when the ID-stage branch unit resolves a taken branch, then flushes the wrong-path fetch. It stops fetch on the halt opcode. It sits between the ID-stage branch resolver and the IF stage and drives the IF/ID flush.

## Interface
- WIDTH, 16, PC and target width
- RESET_PC, 16'h0000, PC value loaded on reset
- FLUSH_CYCLES, 1, number of bubble cycles after a redirect (1..7)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hazard stall; the ID instruction is not ready
- id_valid  in  1  the ID stage holds a real instruction
- id_opcode  in  4  opcode of the ID instruction
- id_pc  in  WIDTH  address of the ID instruction
- branch_target  in  WIDTH  next-PC from the branch resolver: id_pc+offset or id_pc+2
- pc  out  WIDTH  fetch address, registered
- fetch_en  out  1  instruction memory read enable, registered
- flush  out  1  kill the IF/ID contents this cycle, registered
- halted  out  1  core halted, registered
- taken_count  out  16  count of redirects, saturating, registered

## Operation
- States: RUN, FLUSH, HALT.
- The branch opcodes are 4'b0100, 4'b0101 and 4'b0110. The halt opcode is 4'b1111.
- A branch is redirecting when it is a branch opcode, id_valid=1, and branch_target != id_pc+2 (WIDTH-bit wrapping compare). A taken branch with offset 2 therefore does not redirect.

**RUN state.** Rules are applied in this priority order on each edge:
1. If stall=1: the ID instruction is ignored and pc holds.
2. If the halt opcode is present with id_valid=1: go to HALT. pc holds, fetch_en <= 0, halted <= 1.
3. If a branch is redirecting: pc <= branch_target, flush <= 1, taken_count += 1 (saturates at 16'hFFFF), load the flush counter with FLUSH_CYCLES-1, go to FLUSH.
4. Otherwise: pc <= pc+2, wrapping from 16'hFFFE to 16'h0000.

**FLUSH state.**
- id_valid, stall and id_opcode are all ignored, because they describe wrong-path instructions.
- pc <= pc+2 on every edge and flush stays 1.
- When the flush counter reaches 0: flush <= 0 and go to RUN. Otherwise decrement the counter.

**HALT state.** All outputs hold. Only rst leaves this state.

**Reset.**
- Asserting rst at any time, including mid-FLUSH, immediately forces: pc=RESET_PC, fetch_en=0, flush=0, halted=0, taken_count=0, state RUN.
- On the first edge after rst deasserts, fetch_en <= 1 and pc holds RESET_PC. That is the first fetch.
- pc starts advancing on the following edge. On that first edge the RUN rules are not evaluated.

## Timing
- All outputs are registered; none is combinational from the inputs.
- Redirect latency: the branch is in ID during cycle t. In cycle t+1, pc=branch_target and flush=1. In cycle t+1+FLUSH_CYCLES, flush=0 and pc=branch_target+2*FLUSH_CYCLES.
- A stall and a redirecting branch in the same cycle: the stall wins. The branch is re-evaluated in the first non-stall cycle, using the branch_target present in that cycle.
- Halt latency: the halt opcode is in ID during cycle t. From cycle t+1 onward, fetch_en=0 and halted=1.
- A redirecting branch or halt presented during FLUSH has no effect.
- A stall held for N cycles in RUN keeps pc constant for N cycles. There is no limit on N.
- taken_count does not wrap: at 16'hFFFF, further redirects leave it at 16'hFFFF.

## Test plan
- **Reset and sequential fetch.** RESET_PC=16'h0010; deassert rst, no ID activity.
  - Required: fetch_en=1 and pc=16'h0010, then 16'h0012 and 16'h0014 on successive edges.
- **Taken branch.** FLUSH_CYCLES=1, opcode 4'b0100, id_pc=16'h0020, branch_target=16'h0040, id_valid=1.
  - Required: next cycle pc=16'h0040, flush=1, taken_count=1.
  - Cycle after: pc=16'h0042, flush=0.
- **Not-taken branch and stall priority.**
  - branch_target=id_pc+2=16'h0022: no flush and pc keeps incrementing.
  - Same redirecting branch with stall=1 for 3 cycles: pc holds for 3 cycles, then redirects on the first cycle with stall=0.
- **Halt.** Opcode 4'b1111 with id_valid=1 at pc=16'h0030.
  - Required: next cycle fetch_en=0, halted=1, pc=16'h0030, held indefinitely.
  - A later redirecting branch input is ignored.
- **Wrap and flush immunity.** pc reaches 16'hFFFE, then the next pc is 16'h0000. With FLUSH_CYCLES=3, a second redirecting branch presented during the flush window is ignored.
  - Required: flush stays high exactly 3 cycles and taken_count increments once.
- **Reset mid-flush.** Assert rst in the second flush cycle.
  - Required: immediately pc=RESET_PC, flush=0, taken_count=0, fetch_en=0.
